d_issue_stage: RTL

//   D-stage issue block of the 5-stage MIPS pipeline; it consumes the GRF read ports.

---
 rtl/d_issue_stage_pkg.sv | 23 ++
 rtl/d_issue_stage_if.sv | 56 +++++
 rtl/d_issue_stage_fwd_sel.sv | 47 ++++
 rtl/d_issue_stage.sv | 104 ++++++++++
 4 files changed

// File: rtl/d_issue_stage_pkg.sv
// Shared constants and types for the D-stage issue block of the 5-stage MIPS pipeline.
package d_issue_stage_pkg;

    localparam int unsigned TWIDTH    = 2;
    localparam logic [1:0]  TUSE_NONE = 2'd3;
    localparam logic [31:0] NOP_INSTR = 32'd0;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    typedef logic [TWIDTH-1:0] tnew_t;

    typedef enum logic [1:0] {
        FWD_GRF,
        FWD_W,
        FWD_M,
        FWD_E
    } fwd_src_e;

    // A writer hits a source when it writes a non-zero register equal to that source.
    function automatic logic rd_hit(input logic we, input logic [4:0] a3, input logic [4:0] a);
        return we && (a3 != 5'd0) && (a3 == a);
    endfunction

endpackage

// File: rtl/d_issue_stage_if.sv
// D-stage operand/hazard bus: D-stage inputs, M/W producer info and the D/E register outputs.
interface d_issue_stage_if
    import d_issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      D_Instr;
    logic [WIDTH-1:0] D_PC;
    logic [WIDTH-1:0] D_GRF_RD1;
    logic [WIDTH-1:0] D_GRF_RD2;
    logic [4:0]       D_A1;
    logic [4:0]       D_A2;
    logic [4:0]       D_A3;
    logic             D_RegWrite;
    tnew_t            D_Tuse_rs;
    tnew_t            D_Tuse_rt;
    tnew_t            D_Tnew;
    logic [4:0]       M_A3;
    logic             M_RegWrite;
    tnew_t            M_Tnew;
    logic [WIDTH-1:0] M_WD;
    logic [4:0]       W_A3;
    logic             W_RegWrite;
    logic [WIDTH-1:0] W_WD;

    logic             D_Stall;
    logic [WIDTH-1:0] D_FwdRD1;
    logic [WIDTH-1:0] D_FwdRD2;
    logic [31:0]      E_Instr;
    logic [WIDTH-1:0] E_PC;
    logic [WIDTH-1:0] E_RD1;
    logic [WIDTH-1:0] E_RD2;
    logic [4:0]       E_A1;
    logic [4:0]       E_A2;
    logic [4:0]       E_A3;
    logic             E_RegWrite;
    tnew_t            E_Tnew;
    logic             E_Valid;

    modport master (
        output D_Instr, D_PC, D_GRF_RD1, D_GRF_RD2, D_A1, D_A2, D_A3, D_RegWrite,
               D_Tuse_rs, D_Tuse_rt, D_Tnew, M_A3, M_RegWrite, M_Tnew, M_WD,
               W_A3, W_RegWrite, W_WD,
        input  D_Stall, D_FwdRD1, D_FwdRD2, E_Instr, E_PC, E_RD1, E_RD2,
               E_A1, E_A2, E_A3, E_RegWrite, E_Tnew, E_Valid
    );

    modport slave (
        input  D_Instr, D_PC, D_GRF_RD1, D_GRF_RD2, D_A1, D_A2, D_A3, D_RegWrite,
               D_Tuse_rs, D_Tuse_rt, D_Tnew, M_A3, M_RegWrite, M_Tnew, M_WD,
               W_A3, W_RegWrite, W_WD,
        output D_Stall, D_FwdRD1, D_FwdRD2, E_Instr, E_PC, E_RD1, E_RD2,
               E_A1, E_A2, E_A3, E_RegWrite, E_Tnew, E_Valid
    );

endinterface

// File: rtl/d_issue_stage_fwd_sel.sv
// Per-operand bypass mux: picks the newest ready producer (E > M > W) or falls back to the GRF.
module d_issue_stage_fwd_sel
    import d_issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] grf_rd,
    input  logic             e_we,
    input  logic [4:0]       e_a3,
    input  tnew_t            e_tnew,
    input  logic [WIDTH-1:0] e_pc,
    input  logic             m_we,
    input  logic [4:0]       m_a3,
    input  tnew_t            m_tnew,
    input  logic [WIDTH-1:0] m_wd,
    input  logic             w_we,
    input  logic [4:0]       w_a3,
    input  logic [WIDTH-1:0] w_wd,
    output logic [WIDTH-1:0] data
);

    fwd_src_e src;

    always_comb begin
        src = FWD_GRF;
        if (rd_hit(e_we, e_a3, addr) && (e_tnew == '0)) begin
            src = FWD_E;
        end else if (rd_hit(m_we, m_a3, addr) && (m_tnew == '0)) begin
            src = FWD_M;
        end else if (rd_hit(w_we, w_a3, addr)) begin
            src = FWD_W;
        end
    end

    // Only link-type instructions are ready in E; their result is the return address.
    always_comb begin
        data = grf_rd;
        unique case (src)
            FWD_E:   data = e_pc + WIDTH'(8);
            FWD_M:   data = m_wd;
            FWD_W:   data = w_wd;
            default: data = grf_rd;
        endcase
    end

endmodule

// File: rtl/d_issue_stage.sv
// D-stage issue: operand bypass, Tuse/Tnew stall detection and the D/E pipeline register.
module d_issue_stage #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = d_issue_stage_pkg::RESET_PC
) (
    input logic             Clk,
    input logic             Reset_n,
    d_issue_stage_if.slave  bus
);

    import d_issue_stage_pkg::*;

    logic stall_rs;
    logic stall_rt;

    d_issue_stage_fwd_sel #(.WIDTH(WIDTH)) u_fwd_rs (
        .addr   (bus.D_A1),
        .grf_rd (bus.D_GRF_RD1),
        .e_we   (bus.E_RegWrite),
        .e_a3   (bus.E_A3),
        .e_tnew (bus.E_Tnew),
        .e_pc   (bus.E_PC),
        .m_we   (bus.M_RegWrite),
        .m_a3   (bus.M_A3),
        .m_tnew (bus.M_Tnew),
        .m_wd   (bus.M_WD),
        .w_we   (bus.W_RegWrite),
        .w_a3   (bus.W_A3),
        .w_wd   (bus.W_WD),
        .data   (bus.D_FwdRD1)
    );

    d_issue_stage_fwd_sel #(.WIDTH(WIDTH)) u_fwd_rt (
        .addr   (bus.D_A2),
        .grf_rd (bus.D_GRF_RD2),
        .e_we   (bus.E_RegWrite),
        .e_a3   (bus.E_A3),
        .e_tnew (bus.E_Tnew),
        .e_pc   (bus.E_PC),
        .m_we   (bus.M_RegWrite),
        .m_a3   (bus.M_A3),
        .m_tnew (bus.M_Tnew),
        .m_wd   (bus.M_WD),
        .w_we   (bus.W_RegWrite),
        .w_a3   (bus.W_A3),
        .w_wd   (bus.W_WD),
        .data   (bus.D_FwdRD2)
    );

    // A source stalls while a producer in E or M will not be ready by the time it is used.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (bus.D_Tuse_rs != TUSE_NONE) begin
            stall_rs = (rd_hit(bus.E_RegWrite, bus.E_A3, bus.D_A1) && (bus.D_Tuse_rs < bus.E_Tnew))
                    || (rd_hit(bus.M_RegWrite, bus.M_A3, bus.D_A1) && (bus.D_Tuse_rs < bus.M_Tnew));
        end
        if (bus.D_Tuse_rt != TUSE_NONE) begin
            stall_rt = (rd_hit(bus.E_RegWrite, bus.E_A3, bus.D_A2) && (bus.D_Tuse_rt < bus.E_Tnew))
                    || (rd_hit(bus.M_RegWrite, bus.M_A3, bus.D_A2) && (bus.D_Tuse_rt < bus.M_Tnew));
        end
    end

    assign bus.D_Stall = stall_rs | stall_rt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.E_Instr    <= NOP_INSTR;
            bus.E_PC       <= RESET_PC;
            bus.E_RD1      <= '0;
            bus.E_RD2      <= '0;
            bus.E_A1       <= '0;
            bus.E_A2       <= '0;
            bus.E_A3       <= '0;
            bus.E_RegWrite <= 1'b0;
            bus.E_Tnew     <= '0;
            bus.E_Valid    <= 1'b0;
        end else if (bus.D_Stall) begin
            // Bubble still carries the stalled PC so a later exception can report it.
            bus.E_Instr    <= NOP_INSTR;
            bus.E_PC       <= bus.D_PC;
            bus.E_RD1      <= '0;
            bus.E_RD2      <= '0;
            bus.E_A1       <= '0;
            bus.E_A2       <= '0;
            bus.E_A3       <= '0;
            bus.E_RegWrite <= 1'b0;
            bus.E_Tnew     <= '0;
            bus.E_Valid    <= 1'b0;
        end else begin
            bus.E_Instr    <= bus.D_Instr;
            bus.E_PC       <= bus.D_PC;
            bus.E_RD1      <= bus.D_FwdRD1;
            bus.E_RD2      <= bus.D_FwdRD2;
            bus.E_A1       <= bus.D_A1;
            bus.E_A2       <= bus.D_A2;
            bus.E_A3       <= bus.D_A3;
            bus.E_RegWrite <= bus.D_RegWrite;
            bus.E_Tnew     <= bus.D_Tnew;
            bus.E_Valid    <= 1'b1;
        end
    end

endmodule
